// File: rtl/opc5_uart_pkg.sv
// opc5_io_pkg: shared register offsets, STATUS bit indices and UART FSM state types
package opc5_io_pkg;
    localparam int UART_STATUS_OFS = 0;
    localparam int UART_DATA_OFS   = 1;
    localparam int ST_TXNF   = 0;
    localparam int ST_RXV    = 1;
    localparam int ST_OVR    = 2;
    localparam int ST_FERR   = 3;
    localparam int ST_TXIDLE = 4;
    localparam int ST_TXOVF  = 5;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/opc5_uart_if.sv
// opc5_uart_if: OPC5 system bus as seen by a memory-mapped peripheral
// Signals: address/rnw from the CPU, data is the shared tristate bus; the CPU drives it through
//          cpu_wdata/cpu_oe and the peripheral through uart_rdata/uart_oe (the two enables never overlap).
interface opc5_uart_if;
    logic [15:0] address;
    logic        rnw;
    logic [15:0] cpu_wdata;
    logic        cpu_oe;
    logic [15:0] uart_rdata;
    logic        uart_oe;
    wire  [15:0] data;
    assign data = uart_oe ? uart_rdata : cpu_oe ? cpu_wdata : 16'bz;
    modport master (output address, rnw, cpu_wdata, cpu_oe, input data);
    modport slave  (input address, rnw, data, output uart_rdata, uart_oe);
endinterface

// File: rtl/opc5_uart_rx.sv
// opc5_uart_rx: serial receiver with input synchronizer, mid-bit sampling and stop-bit check
// Ports: clk, reset_b (async active-low), rxd_i async serial input (idle high),
//        byte_strobe_o one-cycle valid for byte_o, frame_err_strobe_o one-cycle bad stop bit
module opc5_uart_rx
    import opc5_io_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       rxd_i,
    output logic       byte_strobe_o,
    output logic [7:0] byte_o,
    output logic       frame_err_strobe_o
);
    logic s1_q, s2_q, prev_q;
    rx_state_t st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    assign byte_o = sh_q;
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            st_q   <= RX_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
        end else begin
            s1_q   <= rxd_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
        end
    end
    // After the start edge the counter first runs half a bit, then whole bits, so every
    // later sample lands mid-bit.
    always_comb begin
        st_d = st_q;
        cnt_d = cnt_q + 16'd1;
        bit_d = bit_q;
        sh_d = sh_q;
        byte_strobe_o = 1'b0;
        frame_err_strobe_o = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !s2_q) st_d = RX_START;
            end
            RX_START: if (cnt_q == 16'(CLK_DIV / 2 - 1)) begin
                cnt_d = '0;
                bit_d = '0;
                st_d = s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == 16'(CLK_DIV - 1)) begin
                cnt_d = '0;
                sh_d = {s2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == 16'(CLK_DIV - 1)) begin
                cnt_d = '0;
                byte_strobe_o = s2_q;
                frame_err_strobe_o = !s2_q;
                st_d = s2_q ? RX_IDLE : RX_WAIT_HIGH;
            end
            default: begin
                // A low stop bit may be a break; wait for the line to idle before hunting again.
                cnt_d = '0;
                if (s2_q) st_d = RX_IDLE;
            end
        endcase
    end
endmodule

// File: rtl/opc5_uart.sv
// opc5_uart: memory-mapped UART on the OPC5 bus, 4-deep TX FIFO, single RX holding register
// Ports: clk, reset_b (async active-low), bus (slave side: address/rnw/data, two-word window at
//        BASE_ADDR: STATUS then DATA), rxd_i serial input, txd_o serial output (idle high)
module opc5_uart
    import opc5_io_pkg::*;
#(
    parameter int          CLK_DIV   = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
    input  logic       clk,
    input  logic       reset_b,
    opc5_uart_if.slave bus,
    input  logic       rxd_i,
    output logic       txd_o
);
    logic sel, is_data, wr_data, wr_stat, rd_data, push, pop, tx_idle;
    logic [7:0] mem_q [4];
    logic [1:0] wp_q, rp_q;
    logic [2:0] fcnt_q;
    tx_state_t tx_q, tx_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [2:0] tbit_q, tbit_d;
    logic [7:0] tsh_q, tsh_d;
    logic [7:0] rx_byte_q, rx_byte;
    logic rxv_q, ovr_q, ferr_q, txovf_q, rx_stb, ferr_stb;
    logic [15:0] status;
    opc5_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk                (clk),
        .reset_b            (reset_b),
        .rxd_i              (rxd_i),
        .byte_strobe_o      (rx_stb),
        .byte_o             (rx_byte),
        .frame_err_strobe_o (ferr_stb)
    );
    assign sel     = bus.address[15:1] == BASE_ADDR[15:1];
    assign is_data = bus.address[0] == 1'(UART_DATA_OFS);
    assign wr_data = sel && !bus.rnw && is_data;
    assign wr_stat = sel && !bus.rnw && !is_data;
    assign rd_data = sel && bus.rnw && is_data;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
    assign push    = wr_data && (fcnt_q != 3'd4 || pop);
    assign tx_idle = tx_q == TX_IDLE && fcnt_q == 3'd0;
    always_comb begin
        status = '0;
        status[ST_TXNF]   = fcnt_q != 3'd4;
        status[ST_RXV]    = rxv_q;
        status[ST_OVR]    = ovr_q;
        status[ST_FERR]   = ferr_q;
        status[ST_TXIDLE] = tx_idle;
        status[ST_TXOVF]  = txovf_q;
    end
    assign bus.uart_oe    = sel && bus.rnw;
    assign bus.uart_rdata = is_data ? {8'h00, rx_byte_q} : status;
    // Output is decoded from state so the async reset forces the line idle at once.
    assign txd_o = tx_q == TX_START ? 1'b0 : tx_q == TX_DATA ? tsh_q[0] : 1'b1;
    always_comb begin
        tx_d = tx_q;
        tcnt_d = tcnt_q + 16'd1;
        tbit_d = tbit_q;
        tsh_d = tsh_q;
        pop = 1'b0;
        case (tx_q)
            TX_IDLE: begin
                tcnt_d = '0;
                if (fcnt_q != 3'd0) begin
                    pop = 1'b1;
                    tsh_d = mem_q[rp_q];
                    tx_d = TX_START;
                end
            end
            TX_START: if (tcnt_q == 16'(CLK_DIV - 1)) begin
                tcnt_d = '0;
                tbit_d = '0;
                tx_d = TX_DATA;
            end
            TX_DATA: if (tcnt_q == 16'(CLK_DIV - 1)) begin
                tcnt_d = '0;
                tsh_d = tsh_q >> 1;
                tbit_d = tbit_q + 3'd1;
                if (tbit_q == 3'd7) tx_d = TX_STOP;
            end
            default: if (tcnt_q == 16'(CLK_DIV - 1)) begin
                tcnt_d = '0;
                tx_d = TX_IDLE;
                if (fcnt_q != 3'd0) begin
                    pop = 1'b1;
                    tsh_d = mem_q[rp_q];
                    tx_d = TX_START;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= bus.data[7:0];
    end
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wp_q      <= '0;
            rp_q      <= '0;
            fcnt_q    <= '0;
            tx_q      <= TX_IDLE;
            tcnt_q    <= '0;
            tbit_q    <= '0;
            tsh_q     <= '0;
            rx_byte_q <= '0;
            rxv_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            txovf_q   <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + 2'd1;
            if (pop) rp_q <= rp_q + 2'd1;
            fcnt_q <= fcnt_q + {2'b00, push} - {2'b00, pop};
            tx_q   <= tx_d;
            tcnt_q <= tcnt_d;
            tbit_q <= tbit_d;
            tsh_q  <= tsh_d;
            // A DATA read in the delivery cycle frees the holding register, so no overrun.
            if (rx_stb && (!rxv_q || rd_data)) rx_byte_q <= rx_byte;
            rxv_q   <= rx_stb || (rxv_q && !rd_data);
            ovr_q   <= (rx_stb && rxv_q && !rd_data) || (ovr_q && !(wr_stat && bus.data[ST_OVR]));
            ferr_q  <= ferr_stb || (ferr_q && !(wr_stat && bus.data[ST_FERR]));
            txovf_q <= (wr_data && !push) || (txovf_q && !(wr_stat && bus.data[ST_TXOVF]));
        end
    end
endmodule
